// File: rtl/data_mem_unit.sv
// Word-organised data memory with byte/half/word access, sign/zero extension and alignment/range checking.
// Latency: ack WAIT_STATES+2 cycles after accept; req is ignored while busy, one access per WAIT_STATES+3 cycles.
module data_mem_unit #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_we, r_sext;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;
  logic        r_ack, r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH];

  logic          w_accept, w_done, w_err;
  logic [AW-1:0] w_idx;
  logic [4:0]    w_shamt;
  logic [3:0]    w_be;
  logic [31:0]   w_word, w_rshift, w_wshift, w_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter is held at zero in IDLE so it is already cleared on entry to WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == WS4) begin
          w_done      = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= we;
      r_sext  <= sext;
      r_size  <= size;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  always_comb begin
    case (r_size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = |r_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if (r_addr[31:2] >= 30'(DEPTH)) w_err = 1'b1;
  end

  assign w_idx    = r_addr[AW+1:2];
  assign w_shamt  = {r_addr[1:0], 3'b000};
  assign w_word   = r_mem[w_idx];
  assign w_rshift = w_word >> w_shamt;
  assign w_wshift = r_wdata << w_shamt;

  always_comb begin
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = 4'b0011 << r_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_rshift[7]}},  w_rshift[7:0]};
      2'b01:   w_load = {{16{r_sext & w_rshift[15]}}, w_rshift[15:0]};
      default: w_load = w_rshift;
    endcase
  end

  // Storage has no reset; a reset before the commit edge leaves the FSM in IDLE so nothing is written.
  always_ff @(posedge clk) begin
    if (w_done && r_we && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wshift[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_done) begin
      r_ack   <= 1'b1;
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
    end else begin
      r_ack   <= 1'b0;
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: two instances (0 and 3 wait states) checked against a byte-array memory model.
module tb_data_mem_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_v = 2'b00;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sext_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [1:0]  busy_v, ack_v, err_v;
  logic [31:0] rdata_v [2];

  logic [7:0]  mem_m [2][DEPTH*4];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we_i), .size(size_i), .sext(sext_i),
    .addr(addr_i), .wdata(wdata_i), .busy(busy_v[0]), .ack(ack_v[0]), .err(err_v[0]), .rdata(rdata_v[0])
  );

  data_mem_unit #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we_i), .size(size_i), .sext(sext_i),
    .addr(addr_i), .wdata(wdata_i), .busy(busy_v[1]), .ack(ack_v[1]), .err(err_v[1]), .rdata(rdata_v[1])
  );

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Reference: byte-addressed memory, alignment and range rules applied arithmetically.
  function automatic void model(input int sel, input logic w, input logic [1:0] sz, input logic sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int nb;
    nb = nbytes(sz);
    e  = (sz == 2'b11) || ((a % 32'(nb)) != 0) || (a >= 32'(DEPTH*4));
    rd = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_m[sel][int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rd = rd | (32'(mem_m[sel][int'(a) + i]) << (8*i));
        if (sx && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
      end
    end
  endfunction

  // Called just after a rising edge with the DUT idle; returns just after a rising edge with it idle again.
  task automatic do_access(input int sel, input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd, output int lat, output int nbusy);
    we_i = w; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
    req_v[sel] = 1'b1;
    @(posedge clk); #1;
    req_v[sel] = 1'b0;
    lat = 0;
    nbusy = busy_v[sel] ? 1 : 0;
    while (!ack_v[sel] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[sel]) nbusy++;
    end
    e  = err_v[sel];
    rd = rdata_v[sel];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic e, ee; logic [31:0] rd, er; int lat, nb;
    reset_n = 1'b0;
    #12;
    n_chk++; if (busy_v !== 2'b00) $display("FAIL reset_busy act=%b exp=00", busy_v); else n_pass++;
    n_chk++; if (ack_v !== 2'b00) $display("FAIL reset_ack act=%b exp=00", ack_v); else n_pass++;
    n_chk++; if (err_v !== 2'b00) $display("FAIL reset_err act=%b exp=00", err_v); else n_pass++;
    n_chk++; if (rdata_v[0] !== 32'd0) $display("FAIL reset_rdata0 act=%h exp=0", rdata_v[0]); else n_pass++;
    n_chk++; if (rdata_v[1] !== 32'd0) $display("FAIL reset_rdata3 act=%h exp=0", rdata_v[1]); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, ee, er);
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, e, rd, lat, nb);
    n_chk++; if (nb !== 2) $display("FAIL first_edge_busy act=%0d exp=2", nb); else n_pass++;
    n_chk++; if (lat !== 1) $display("FAIL first_edge_lat act=%0d exp=1", lat); else n_pass++;
  endtask

  task automatic test_init();
    logic e, ee; logic [31:0] rd, er, d; int lat, nb;
    for (int sel = 0; sel < 2; sel++) begin
      for (int w = 0; w < DEPTH; w++) begin
        d = $urandom;
        model(sel, 1'b1, 2'b10, 1'b0, 32'(w*4), d, ee, er);
        do_access(sel, 1'b1, 2'b10, 1'b0, 32'(w*4), d, e, rd, lat, nb);
        n_chk++; if (e !== ee || rd !== er) $display("FAIL init_store sel=%0d w=%0d act=%b/%h exp=%b/%h", sel, w, e, rd, ee, er); else n_pass++;
      end
    end
  endtask

  task automatic test_directed();
    logic e, ee; logic [31:0] rd, er; int lat, nb;
    logic [31:0] ea [6];
    logic [1:0]  es [6];
    logic        ew [6];
    model(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ee, er);
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, e, rd, lat, nb);
    n_chk++; if (e !== 1'b0 || lat !== 1) $display("FAIL store_word act=err%b/lat%0d exp=err0/lat1", e, lat); else n_pass++;
    model(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ee, er);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL load_word act=%h/%b exp=deadbeef/0", rd, e); else n_pass++;
    n_chk++; if (lat !== 1 || nb !== 2) $display("FAIL load_word_lat act=%0d/%0d exp=1/2", lat, nb); else n_pass++;
    model(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, ee, er);
    do_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, e, rd, lat, nb);
    model(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h55AA1280, ee, er);
    do_access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h55AA1280, e, rd, lat, nb);
    n_chk++; if (rd !== 32'd0 || e !== 1'b0) $display("FAIL store_byte act=%h/%b exp=0/0", rd, e); else n_pass++;
    model(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, ee, er);
    do_access(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'hFFFFFF80) $display("FAIL load_byte_sext act=%h exp=ffffff80", rd); else n_pass++;
    model(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, ee, er);
    do_access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'h00000080) $display("FAIL load_byte_zext act=%h exp=00000080", rd); else n_pass++;
    model(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ee, er);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'h00008000) $display("FAIL load_word_after_byte act=%h exp=00008000", rd); else n_pass++;
    ea = '{32'h13, 32'h12, 32'h10, 32'h100, 32'h100, 32'h13};
    es = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01};
    ew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      model(0, ew[i], es[i], 1'b1, ea[i], 32'hFFFFFFFF, ee, er);
      do_access(0, ew[i], es[i], 1'b1, ea[i], 32'hFFFFFFFF, e, rd, lat, nb);
      n_chk++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL err_case%0d act=%b/%h exp=1/0", i, e, rd); else n_pass++;
    end
    do_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'h00008000) $display("FAIL err_no_write act=%h exp=00008000", rd); else n_pass++;
    model(0, 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, ee, er);
    do_access(0, 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== er || e !== 1'b0) $display("FAIL last_word act=%h/%b exp=%h/0", rd, e, er); else n_pass++;
  endtask

  task automatic test_wait3();
    logic e, ee, ack_e; logic [31:0] rd, er, a; logic [1:0] sz; int nb, na, ackpos;
    for (int it = 0; it < 6; it++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, DEPTH*4-1)) & ~32'(nbytes(sz) - 1);
      model(1, 1'b0, sz, it[0], a, 32'h0, ee, er);
      we_i = 1'b0; size_i = sz; sext_i = it[0]; addr_i = a;
      req_v[1] = 1'b1;
      @(posedge clk); #1;
      nb = 0; na = 0; ackpos = 0; rd = '0; ack_e = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (busy_v[1]) nb++;
        if (ack_v[1]) begin na++; ackpos = nb; rd = rdata_v[1]; ack_e = err_v[1]; end
        req_v[1] = busy_v[1] ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
      req_v[1] = 1'b0;
      n_chk++; if (nb !== 5) $display("FAIL w3_busy_cycles act=%0d exp=5", nb); else n_pass++;
      n_chk++; if (na !== 1 || ackpos !== 5) $display("FAIL w3_ack act=n%0d/pos%0d exp=n1/pos5", na, ackpos); else n_pass++;
      n_chk++; if (rd !== er || ack_e !== ee) $display("FAIL w3_data act=%h/%b exp=%h/%b", rd, ack_e, er, ee); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic e, ee, w, sx; logic [31:0] rd, er, a, d; logic [1:0] sz; int lat, nb, sel;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 1);
      w   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      sx  = 1'($urandom_range(0, 1));
      d   = $urandom;
      a   = 32'($urandom_range(0, DEPTH*4 + 31));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & 32'(DEPTH*4 - 1) & ~32'(nbytes(sz) - 1);
      model(sel, w, sz, sx, a, d, ee, er);
      do_access(sel, w, sz, sx, a, d, e, rd, lat, nb);
      n_chk++; if (e !== ee || rd !== er) $display("FAIL rand%0d sel=%0d act=%b/%h exp=%b/%h", it, sel, e, rd, ee, er); else n_pass++;
      n_chk++; if (lat !== ws_of(sel) + 1 || nb !== ws_of(sel) + 2) $display("FAIL rand_timing%0d act=%0d/%0d exp=%0d/%0d", it, lat, nb, ws_of(sel) + 1, ws_of(sel) + 2); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic ee, w, sx; logic [31:0] er, a, base, d; logic [1:0] sz; int c;
    for (int sel = 0; sel < 2; sel++) begin
      base = '0;
      req_v[sel] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (!i[0]) begin
          base = 32'($urandom_range(0, DEPTH-1) * 4);
          w = 1'b1; sz = 2'b10; sx = 1'b0; a = base; d = $urandom;
        end else begin
          w = 1'b0; sz = 2'($urandom_range(0, 2)); sx = 1'($urandom_range(0, 1));
          a = base + (32'($urandom_range(0, 3)) & ~32'(nbytes(sz) - 1)); d = $urandom;
        end
        we_i = w; size_i = sz; sext_i = sx; addr_i = a; wdata_i = d;
        model(sel, w, sz, sx, a, d, ee, er);
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!ack_v[sel] && c < 50);
        n_chk++; if (c !== ((i == 0) ? ws_of(sel) + 2 : ws_of(sel) + 3)) $display("FAIL b2b_period sel=%0d i=%0d act=%0d exp=%0d", sel, i, c, (i == 0) ? ws_of(sel) + 2 : ws_of(sel) + 3); else n_pass++;
        n_chk++; if (err_v[sel] !== ee || rdata_v[sel] !== er) $display("FAIL b2b_data sel=%0d i=%0d act=%b/%h exp=%b/%h", sel, i, err_v[sel], rdata_v[sel], ee, er); else n_pass++;
      end
      req_v[sel] = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (busy_v[sel] !== 1'b0) $display("FAIL b2b_idle sel=%0d act=%b exp=0", sel, busy_v[sel]); else n_pass++;
    end
  endtask

  task automatic test_reset_abort(input int sel);
    logic e, ee; logic [31:0] rd, er; int lat, nb;
    model(sel, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, ee, er);
    do_access(sel, 1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, e, rd, lat, nb);
    do_access(sel, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'hAAAAAAAA) $display("FAIL abort_pre sel=%0d act=%h exp=aaaaaaaa", sel, rd); else n_pass++;
    we_i = 1'b1; size_i = 2'b10; addr_i = 32'h20; wdata_i = 32'h12345678;
    req_v[sel] = 1'b1;
    @(posedge clk); #1;
    req_v[sel] = 1'b0;
    if (ws_of(sel) > 0) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (busy_v[sel] !== 1'b0 || ack_v[sel] !== 1'b0 || err_v[sel] !== 1'b0) $display("FAIL abort_ctrl sel=%0d act=%b%b%b exp=000", sel, busy_v[sel], ack_v[sel], err_v[sel]); else n_pass++;
    n_chk++; if (rdata_v[sel] !== 32'd0) $display("FAIL abort_rdata sel=%0d act=%h exp=0", sel, rdata_v[sel]); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    do_access(sel, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e, rd, lat, nb);
    n_chk++; if (rd !== 32'hAAAAAAAA || e !== 1'b0) $display("FAIL abort_post sel=%0d act=%h/%b exp=aaaaaaaa/0", sel, rd, e); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_wait3();
    test_random();
    test_back_to_back();
    test_reset_abort(0);
    test_reset_abort(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words of storage (power of two, >=4).
REQ-002 SHALL have parameter WAIT_STATES, default 0, meaning extra cycles inserted before each access completes (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port sext  input  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for word and stores.
REQ-009 SHALL have port addr  input  32  byte address.
REQ-010 SHALL have port wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  valid with ack; 1 = access rejected.
REQ-014 SHALL have port rdata  output  32  load result, valid with ack; held until next ack.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; IDLE+req -> WAIT (latch we, size, sext, addr, wdata); WAIT -> RESP when wait counter equals WAIT_STATES; RESP -> IDLE unconditionally.
REQ-016 SHALL clear the wait counter on entry to WAIT and increment it each WAIT cycle; with WAIT_STATES=0, WAIT lasts exactly one cycle.
REQ-017 SHALL assert ack only in RESP, so ack rises WAIT_STATES+2 edges after the accepting edge-1 (i.e. accept edge E, ack high during cycle after edge E+WAIT_STATES+1).
REQ-018 SHALL ignore req while busy; a req held high in the RESP->IDLE cycle is accepted on the next edge (back-to-back throughput one access per WAIT_STATES+3 cycles).
REQ-019 SHALL index storage by addr[log2(DEPTH)+1:2]; byte lane k=addr[1:0] occupies bits [8k+7:8k] (little-endian).
REQ-020 SHALL flag err for: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH.
REQ-021 SHALL, on err, perform no storage write and drive rdata=0.
REQ-022 SHALL commit stores on the WAIT->RESP edge, writing only the addressed lanes (byte: 1 lane, half: lanes k,k+1, word: all four); other lanes unchanged.
REQ-023 SHALL form load data from storage on the WAIT->RESP edge: extract addressed byte/half, extend per sext to 32 bits; stores drive rdata=0.
REQ-024 SHALL keep storage contents unaffected by reset; storage is uninitialised (X) at power-up.
REQ-025 SHALL register rdata, ack, err; no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE, counter=0, busy=0, ack=0, err=0, rdata=0, independent of clk.
REQ-027 SHALL abort an in-flight access on reset assertion: if reset asserts before the commit edge, no storage write occurs.
REQ-028 SHALL accept a req on the first rising edge after reset_n deasserts.

Verification
REQ-029 WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> ack 2 cycles after accept, err=0, rdata=0xDEADBEEF.
REQ-030 Store byte 0x80 @0x11 over word 0x00000000 @0x10, then load byte sext=1 @0x11 -> rdata=0xFFFFFF80; sext=0 -> 0x00000080; load word @0x10 -> 0x00008000.
REQ-031 Load half @0x13 and word @0x12, size=11, addr=0x100 (DEPTH=64) -> each ack with err=1, rdata=0, storage unchanged.
REQ-032 WAIT_STATES=3: busy high 5 cycles per access, ack on 5th; req pulses during busy ignored (exactly one ack per accepted req).
REQ-033 Assert reset_n=0 mid-WAIT of a store word 0x12345678 to 0x20 holding 0xAAAAAAAA -> outputs zero immediately; later load @0x20 returns 0xAAAAAAAA.
REQ-034 Hold req high continuously with alternating store/load -> accesses accepted back-to-back per REQ-018, all data correct.
